serial_code_converter: RTL and testbench



---
 rtl/serial_code_converter_if.sv | 25 ++
 rtl/serial_code_converter.sv | 109 ++++++++++
 tb/tb_serial_code_converter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/serial_code_converter_if.sv
// Bundle of the serial converter's handshake, serial and parallel-result signals.
// The master side feeds code bits; the slave side is the converter.
interface serial_code_converter_if #(
  parameter int WIDTH = 5
);
  logic             start;
  logic             select;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_out;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (
    output start, select, bit_in, bit_valid,
    input  bit_out, out_valid, result, busy, done
  );

  modport slave (
    input  start, select, bit_in, bit_valid,
    output bit_out, out_valid, result, busy, done
  );
endinterface

// File: rtl/serial_code_converter.sv
// Bit-serial binary<->Gray converter: MSB-first input, registered serial output
// plus the assembled parallel word.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; latches direction on accept
//   ST_SHIFT | converting one bit per beat with bit_valid high
//   ST_DONE  | one-cycle done pulse, result final, then back to idle
module serial_code_converter #(
  parameter int WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_code_converter_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic             mode_q;
  logic             prev_q;
  logic [CW-1:0]    count_q;
  logic             bit_out_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;

  logic             conv_d;
  logic             prev_d;
  logic [WIDTH-1:0] result_d;

  // prev is the previous input bit (bin->Gray) or previous output bit (Gray->bin)
  assign conv_d   = bus.bit_in ^ prev_q;
  assign prev_d   = mode_q ? conv_d : bus.bit_in;
  assign result_d = {result_q[WIDTH-2:0], conv_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      prev_q      <= 1'b0;
      count_q     <= '0;
      bit_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
          if (bus.start) begin
            state_q  <= ST_SHIFT;
            mode_q   <= bus.select;
            prev_q   <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (bus.bit_valid) begin
            bit_out_q   <= conv_d;
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            prev_q      <= prev_d;
            count_q     <= count_q + CW'(1);
            if (count_q == LAST_CNT) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            out_valid_q <= 1'b0;
          end
        end

        ST_DONE: begin
          state_q     <= ST_IDLE;
          done_q      <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end

        default: begin
          state_q     <= ST_IDLE;
          done_q      <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bit_out   = bit_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_code_converter.sv
// Directed and randomized checks of serial_code_converter against an
// arithmetic binary/Gray reference model.
module tb_serial_code_converter;

  localparam int W = 5;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   mon_cnt;
  int   mon_done;

  serial_code_converter_if #(.WIDTH(W)) sif ();

  serial_code_converter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses per word, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.out_valid === 1'b1) mon_cnt = mon_cnt + 1;
      if (sif.done === 1'b1) mon_done = mon_done + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp)
    else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full word; starts driving at the current time (just after a rising edge).
  task automatic run_word(input logic sel, input logic [W-1:0] word, input logic [W-1:0] exp,
                          input int stall_at, input int stall_len, input int poke_at);
    mon_cnt       = 0;
    mon_done      = 0;
    sif.start     = 1'b1;
    sif.select    = sel;
    sif.bit_valid = 1'($urandom_range(0, 1));
    sif.bit_in    = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    sif.start     = 1'b0;
    sif.bit_valid = 1'b0;
    check("start_busy", 32'(sif.busy), 32'd1);
    check("start_result_clr", 32'(sif.result), 32'd0);
    check("start_ov", 32'(sif.out_valid), 32'd0);
    for (int i = 0; i < W; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          sif.bit_valid = 1'b0;
          sif.bit_in    = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          check("stall_ov", 32'(sif.out_valid), 32'd0);
          check("stall_busy", 32'(sif.busy), 32'd1);
        end
      end
      sif.bit_valid = 1'b1;
      sif.bit_in    = word[W-1-i];
      if (i == poke_at) begin
        sif.start  = 1'b1;
        sif.select = ~sel;
      end
      @(posedge clk); #1;
      sif.start  = 1'b0;
      sif.select = 1'($urandom_range(0, 1));
      check("beat_ov", 32'(sif.out_valid), 32'd1);
      check("beat_bit", 32'(sif.bit_out), 32'(exp[W-1-i]));
      check("beat_busy", 32'(sif.busy), 32'd1);
      check("beat_done", 32'(sif.done), (i == W - 1) ? 32'd1 : 32'd0);
    end
    // Beat offered in DONE must be dropped
    sif.bit_valid = 1'($urandom_range(0, 1));
    sif.bit_in    = 1'($urandom_range(0, 1));
    check("done_result", 32'(sif.result), 32'(exp));
    @(posedge clk); #1;
    sif.bit_valid = 1'b0;
    check("idle_done", 32'(sif.done), 32'd0);
    check("idle_busy", 32'(sif.busy), 32'd0);
    check("idle_ov", 32'(sif.out_valid), 32'd0);
    check("idle_result_hold", 32'(sif.result), 32'(exp));
    check("ov_pulses", 32'(mon_cnt), 32'(W));
    check("done_pulses", 32'(mon_done), 32'd1);
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] g;
    logic         s;
    total         = 0;
    bad           = 0;
    mon_cnt       = 0;
    mon_done      = 0;
    rst_n         = 1'b0;
    sif.start     = 1'b0;
    sif.select    = 1'b0;
    sif.bit_in    = 1'b0;
    sif.bit_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_bit_out", 32'(sif.bit_out), 32'd0);
    check("rst_ov", 32'(sif.out_valid), 32'd0);
    check("rst_result", 32'(sif.result), 32'd0);
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_done", 32'(sif.done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_word(1'b0, 5'b00100, 5'b00110, -1, 0, -1);
    run_word(1'b1, 5'b01110, 5'b01011, -1, 0, -1);
    run_word(1'b0, 5'b11111, 5'b10000, 3, 2, -1);
    run_word(1'b0, 5'b00100, 5'b00110, -1, 0, 2);
    run_word(1'b1, 5'b01110, 5'b01011, -1, 0, -1);

    // Reset after three beats of a word
    mon_done   = 0;
    sif.start  = 1'b1;
    sif.select = 1'b0;
    @(posedge clk); #1;
    sif.start = 1'b0;
    v = 5'b10110;
    for (int i = 0; i < 3; i++) begin
      sif.bit_valid = 1'b1;
      sif.bit_in    = v[W-1-i];
      @(posedge clk); #1;
    end
    check("pre_rst_busy", 32'(sif.busy), 32'd1);
    sif.bit_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bit_out", 32'(sif.bit_out), 32'd0);
    check("arst_ov", 32'(sif.out_valid), 32'd0);
    check("arst_result", 32'(sif.result), 32'd0);
    check("arst_busy", 32'(sif.busy), 32'd0);
    check("arst_done", 32'(sif.done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_done", 32'(mon_done), 32'd0);
    check("post_rst_busy", 32'(sif.busy), 32'd0);
    run_word(1'b0, 5'b00100, 5'b00110, -1, 0, -1);

    // Exhaustive sweep in both directions plus round trip
    for (int n = 0; n < (1 << W); n++) begin
      v = W'(n);
      g = bin2gray(v);
      run_word(1'b0, v, g, int'($urandom_range(0, W)), int'($urandom_range(1, 2)), -1);
      run_word(1'b1, v, gray2bin(v), -1, 0, int'($urandom_range(0, W)));
      run_word(1'b1, g, v, -1, 0, -1);
    end

    // Random words with random stalls and ignored restart attempts
    for (int n = 0; n < 40; n++) begin
      v = W'($urandom);
      s = 1'($urandom_range(0, 1));
      run_word(s, v, s ? gray2bin(v) : bin2gray(v),
               int'($urandom_range(0, W)), int'($urandom_range(1, 3)), int'($urandom_range(0, W)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
